// File: rtl/turf_trigger_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : turf_trigger_arbiter
// Description : Merges enabled trigger-source edges through a holdoff timer
//               and a ring of event buffers; counts accepted and lost edges.
// Revision    : 1.0 - initial release
// ============================================================================
module turf_trigger_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BUF_BITS  = 2,
    parameter int HOLDOFF_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_SRC-1:0]      src_i,
    input  logic [NUM_SRC-1:0]      src_en_i,
    input  logic                    disable_i,
    input  logic [HOLDOFF_W-1:0]    holdoff_i,
    input  logic                    clr_evt_i,
    output logic                    trig_o,
    output logic [BUF_BITS-1:0]     trig_buf_o,
    output logic [NUM_SRC-1:0]      trig_type_o,
    output logic [(2**BUF_BITS)-1:0] buf_status_o,
    output logic                    busy_o,
    output logic [31:0]             evt_count_o,
    output logic [15:0]             lost_count_o
);

    localparam int                  c_NUM_BUF = 2**BUF_BITS;
    localparam logic [BUF_BITS:0]   c_FULL    = (BUF_BITS+1)'(c_NUM_BUF);
    localparam logic [0:0]          c_IDLE    = 1'b0;
    localparam logic [0:0]          c_HOLDOFF = 1'b1;

    logic [NUM_SRC-1:0]     r_src_d;
    logic [0:0]             r_state;
    logic [HOLDOFF_W-1:0]   r_hold_cnt;
    logic [BUF_BITS-1:0]    r_wr_ptr;
    logic [BUF_BITS-1:0]    r_rd_ptr;
    logic [BUF_BITS:0]      r_occ;
    logic [c_NUM_BUF-1:0]   r_buf_status;
    logic                   r_busy;
    logic                   r_trig;
    logic [BUF_BITS-1:0]    r_trig_buf;
    logic [NUM_SRC-1:0]     r_trig_type;
    logic [31:0]            r_evt_count;
    logic [15:0]            r_lost_count;

    logic [NUM_SRC-1:0]     w_edge;
    logic                   w_any_edge;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_clr;
    logic [BUF_BITS:0]      w_occ_nxt;
    logic [c_NUM_BUF-1:0]   w_status_nxt;

    assign w_edge     = src_i & ~r_src_d & src_en_i;
    assign w_any_edge = |w_edge;
    // Full check uses registered occupancy, so a same-cycle clear cannot make room.
    assign w_accept   = (r_state == c_IDLE) && w_any_edge && !disable_i && !r_busy;
    assign w_reject   = w_any_edge && !w_accept;
    assign w_clr      = clr_evt_i && (r_occ != '0);

    always_comb begin
        w_status_nxt = r_buf_status;
        w_occ_nxt    = r_occ;
        if (w_clr) begin
            w_status_nxt[r_rd_ptr] = 1'b0;
        end
        if (w_accept) begin
            w_status_nxt[r_wr_ptr] = 1'b1;
        end
        if (w_accept && !w_clr) begin
            w_occ_nxt = r_occ + 1'b1;
        end else if (!w_accept && w_clr) begin
            w_occ_nxt = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Track the live level so a source held high across reset never fires.
            r_src_d      <= src_i;
            r_state      <= c_IDLE;
            r_hold_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_buf_status <= '0;
            r_busy       <= 1'b0;
            r_trig       <= 1'b0;
            r_trig_buf   <= '0;
            r_trig_type  <= '0;
            r_evt_count  <= '0;
            r_lost_count <= '0;
        end else begin
            r_src_d      <= src_i;
            r_trig       <= w_accept;
            r_occ        <= w_occ_nxt;
            r_buf_status <= w_status_nxt;
            r_busy       <= (w_occ_nxt == c_FULL);

            if (w_accept) begin
                r_trig_buf  <= r_wr_ptr;
                r_trig_type <= w_edge;
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_evt_count <= r_evt_count + 1'b1;
                r_hold_cnt  <= holdoff_i;
                r_state     <= (holdoff_i != '0) ? c_HOLDOFF : c_IDLE;
            end else if (r_state == c_HOLDOFF) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
                if (r_hold_cnt == HOLDOFF_W'(1)) begin
                    r_state <= c_IDLE;
                end
            end

            if (w_reject && (r_lost_count != 16'hFFFF)) begin
                r_lost_count <= r_lost_count + 1'b1;
            end

            if (w_clr) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign trig_o       = r_trig;
    assign trig_buf_o   = r_trig_buf;
    assign trig_type_o  = r_trig_type;
    assign buf_status_o = r_buf_status;
    assign busy_o       = r_busy;
    assign evt_count_o  = r_evt_count;
    assign lost_count_o = r_lost_count;

endmodule
`default_nettype wire

// File: tb/tb_turf_trigger_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_turf_trigger_arbiter
// Description : Directed vector table plus randomized model-checked stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_trigger_arbiter;

    localparam int c_NB = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  src_i;
    logic [3:0]  src_en_i;
    logic        disable_i;
    logic [7:0]  holdoff_i;
    logic        clr_evt_i;
    logic        trig_o;
    logic [1:0]  trig_buf_o;
    logic [3:0]  trig_type_o;
    logic [3:0]  buf_status_o;
    logic        busy_o;
    logic [31:0] evt_count_o;
    logic [15:0] lost_count_o;

    turf_trigger_arbiter #(.NUM_SRC(4), .BUF_BITS(2), .HOLDOFF_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .src_i        (src_i),
        .src_en_i     (src_en_i),
        .disable_i    (disable_i),
        .holdoff_i    (holdoff_i),
        .clr_evt_i    (clr_evt_i),
        .trig_o       (trig_o),
        .trig_buf_o   (trig_buf_o),
        .trig_type_o  (trig_type_o),
        .buf_status_o (buf_status_o),
        .busy_o       (busy_o),
        .evt_count_o  (evt_count_o),
        .lost_count_o (lost_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  src;
        logic [3:0]  en;
        logic        dis;
        logic [7:0]  hold;
        logic        clr;
        logic [59:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: occupied buffers as a FIFO of indices, holdoff as the
    // earliest cycle number at which a new trigger may be accepted.
    int          m_cyc = 0;
    int          m_next_ok = 0;
    int          m_wr = 0;
    int          m_q[$];
    logic [3:0]  m_prev = '0;
    logic        m_trig = 1'b0;
    logic [1:0]  m_b = '0;
    logic [3:0]  m_type = '0;
    logic [31:0] m_evt = '0;
    int          m_lost = 0;

    function automatic logic [59:0] pk(input logic t, input logic [1:0] b, input logic [3:0] ty,
                                       input logic [3:0] st, input logic bz, input logic [31:0] ev,
                                       input logic [15:0] lo);
        return {t, b, ty, st, bz, ev, lo};
    endfunction

    task automatic add(input logic rst, input logic [3:0] src, input logic [3:0] en, input logic dis,
                       input logic [7:0] hold, input logic clr, input logic t, input logic [1:0] b,
                       input logic [3:0] ty, input logic [3:0] st, input logic bz,
                       input logic [31:0] ev, input logic [15:0] lo);
        vec_t v;
        v.rst = rst; v.src = src; v.en = en; v.dis = dis; v.hold = hold; v.clr = clr;
        v.exp = pk(t, b, ty, st, bz, ev, lo);
        vecs.push_back(v);
    endtask

    task automatic model_step(input logic rst, input logic [3:0] src, input logic [3:0] en,
                              input logic dis, input logic [7:0] hold, input logic clr);
        logic [3:0] e;
        logic       acc;
        int         old_wr;
        if (rst) begin
            m_q.delete();
            m_wr = 0; m_next_ok = 0; m_trig = 0; m_b = '0; m_type = '0; m_evt = '0; m_lost = 0;
        end else begin
            e      = src & ~m_prev & en;
            acc    = (e != 0) && !dis && (m_q.size() < c_NB) && (m_cyc >= m_next_ok);
            old_wr = m_wr;
            m_trig = acc;
            if (clr && m_q.size() > 0) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back(old_wr);
                m_b       = 2'(old_wr);
                m_type    = e;
                m_wr      = (m_wr + 1) % c_NB;
                m_evt     = m_evt + 1;
                m_next_ok = m_cyc + int'(hold) + 1;
            end else if (e != 0) begin
                m_lost = (m_lost < 65535) ? m_lost + 1 : 65535;
            end
        end
        m_prev = src;
        m_cyc++;
    endtask

    function automatic logic [59:0] model_exp();
        logic [3:0] st;
        st = '0;
        foreach (m_q[i]) st[m_q[i]] = 1'b1;
        return pk(m_trig, m_b, m_type, st, m_q.size() == c_NB, m_evt, 16'(m_lost));
    endfunction

    task automatic apply(input logic rst, input logic [3:0] src, input logic [3:0] en,
                         input logic dis, input logic [7:0] hold, input logic clr);
        @(negedge clk);
        rst_i = rst; src_i = src; src_en_i = en; disable_i = dis; holdoff_i = hold; clr_evt_i = clr;
        model_step(rst, src, en, dis, hold, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [59:0] exp);
        logic [59:0] got;
        got = {trig_o, trig_buf_o, trig_type_o, buf_status_o, busy_o, evt_count_o, lost_count_o};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got trig=%0b buf=%0d type=%b status=%b busy=%0b evt=%0d lost=%0d; expected trig=%0b buf=%0d type=%b status=%b busy=%0b evt=%0d lost=%0d",
                     name, got[59], got[58:57], got[56:53], got[52:49], got[48], got[47:16], got[15:0],
                     exp[59], exp[58:57], exp[56:53], exp[52:49], exp[48], exp[47:16], exp[15:0]);
        end
    endtask

    initial begin
        rst_i = 1'b1; src_i = '0; src_en_i = 4'hF; disable_i = 1'b0; holdoff_i = '0; clr_evt_i = 1'b0;

        //   rst src      en       dis hold clr   trig buf type     status   busy evt lost
        add(1, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(1, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   1, 0, 4'b0001, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   0, 0, 4'b0001, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0001, 4'b0001, 0, 1, 0);
        add(0, 4'b0110, 4'b0111, 0, 0, 0,   1, 1, 4'b0110, 4'b0011, 0, 2, 0);
        add(0, 4'b1000, 4'b0111, 0, 0, 0,   0, 1, 4'b0110, 4'b0011, 0, 2, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 1, 4'b0110, 4'b0011, 0, 2, 0);
        // holdoff 5, edges three cycles apart
        add(0, 4'b0001, 4'b1111, 0, 5, 0,   1, 2, 4'b0001, 4'b0111, 0, 3, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 2, 4'b0001, 4'b0111, 0, 3, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 2, 4'b0001, 4'b0111, 0, 3, 0);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   0, 2, 4'b0001, 4'b0111, 0, 3, 1);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 2, 4'b0001, 4'b0111, 0, 3, 1);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 2, 4'b0001, 4'b0111, 0, 3, 1);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   1, 3, 4'b0001, 4'b1111, 1, 4, 1);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 3, 4'b0001, 4'b1111, 1, 4, 1);
        // full: edge rejected despite same-cycle clear
        add(0, 4'b0001, 4'b1111, 0, 0, 1,   0, 3, 4'b0001, 4'b1110, 0, 4, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 3, 4'b0001, 4'b1110, 0, 4, 2);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   1, 0, 4'b0001, 4'b1111, 1, 5, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 0, 4'b0001, 4'b1101, 0, 5, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 0, 4'b0001, 4'b1001, 0, 5, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 0, 4'b0001, 4'b0001, 0, 5, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 0, 4'b0001, 4'b0000, 0, 5, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 0, 4'b0001, 4'b0000, 0, 5, 2);
        // simultaneous trigger and clear with two occupied
        add(0, 4'b0010, 4'b1111, 0, 0, 0,   1, 1, 4'b0010, 4'b0010, 0, 6, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 1, 4'b0010, 4'b0010, 0, 6, 2);
        add(0, 4'b0010, 4'b1111, 0, 0, 0,   1, 2, 4'b0010, 4'b0110, 0, 7, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 2, 4'b0010, 4'b0110, 0, 7, 2);
        add(0, 4'b0100, 4'b1111, 0, 0, 1,   1, 3, 4'b0100, 4'b1100, 0, 8, 2);
        add(0, 4'b0000, 4'b1111, 0, 0, 1,   0, 3, 4'b0100, 4'b1000, 0, 8, 2);
        add(0, 4'b0001, 4'b1111, 0, 0, 0,   1, 0, 4'b0001, 4'b1001, 0, 9, 2);
        // source held high across reset, then reset mid-holdoff
        add(1, 4'b1111, 4'b1111, 0, 7, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 4'b1111, 0, 3, 0,   1, 0, 4'b0001, 4'b0001, 0, 1, 0);
        add(1, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 4'b1111, 0, 0, 0,   1, 0, 4'b0010, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b1111, 0, 0, 0,   0, 0, 4'b0010, 4'b0001, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].src, vecs[i].en, vecs[i].dis, vecs[i].hold, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Randomized traffic against the model
        apply(1, 4'b0000, 4'hF, 0, 0, 0);
        check("rnd_reset", model_exp());
        for (int i = 0; i < 3000; i++) begin
            logic       r_rst, r_dis, r_clr;
            logic [3:0] r_src, r_en;
            logic [7:0] r_hold;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_src  = 4'($urandom);
            r_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            r_dis  = ($urandom_range(0, 9) == 0);
            r_hold = 8'($urandom_range(0, 3));
            r_clr  = ($urandom_range(0, 9) < 3);
            apply(r_rst, r_src, r_en, r_dis, r_hold, r_clr);
            check($sformatf("rnd%0d", i), model_exp());
        end

        // Lost counter saturation: an edge every cycle while disabled
        apply(1, 4'b0000, 4'hF, 0, 0, 0);
        check("sat_reset", pk(0, 0, 4'b0000, 4'b0000, 0, 0, 16'h0000));
        for (int i = 0; i < 65540; i++) begin
            apply(0, (i % 2 == 0) ? 4'b0001 : 4'b0010, 4'hF, 1, 0, 0);
            if (i == 65533) check("sat_before", pk(0, 0, 4'b0000, 4'b0000, 0, 0, 16'hFFFE));
        end
        check("sat_final", pk(0, 0, 4'b0000, 4'b0000, 0, 0, 16'hFFFF));
        check("sat_model", model_exp());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/turf_trigger_arbiter.md
# turf_trigger_arbiter

Parametrised trigger-source arbiter for the TURF trigger path. Merges `NUM_SRC` synchronous trigger sources (soft, external, PPS1, PPS2, …) through per-source enables, a master disable, a programmable holdoff and a `2**BUF_BITS`-deep ring of event buffers. Each accepted trigger produces a one-cycle pulse tagged with a buffer index and a source-type vector. Rejected edges are counted. It sits between the register interface and the HOLD/command logic, and replaces fixed OR-ing of trigger sources.

## Interface
Parameters:
- `NUM_SRC`, 4: number of trigger sources.
- `BUF_BITS`, 2: buffer index width; `NUM_BUF = 2**BUF_BITS`.
- `HOLDOFF_W`, 8: holdoff counter width.

Ports:
- `clk_i`, in, 1: single clock; all logic on its rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `src_i`, in, `NUM_SRC`: trigger source levels, already synchronous to `clk_i`.
- `src_en_i`, in, `NUM_SRC`: per-source enable.
- `disable_i`, in, 1: master disable; rejects all edges.
- `holdoff_i`, in, `HOLDOFF_W`: dead cycles after each accepted trigger.
- `clr_evt_i`, in, 1: one-cycle pulse; frees the oldest occupied buffer.
- `trig_o`, out, 1: one-cycle accepted-trigger pulse.
- `trig_buf_o`, out, `BUF_BITS`: buffer index for `trig_o`; held until the next trigger.
- `trig_type_o`, out, `NUM_SRC`: enabled-edge vector that caused `trig_o`; held until the next trigger.
- `buf_status_o`, out, `NUM_BUF`: buffer occupancy bitmap.
- `busy_o`, out, 1: all buffers occupied.
- `evt_count_o`, out, 32: accepted-trigger count; wraps at 2^32.
- `lost_count_o`, out, 16: rejected-edge cycles; saturates at 0xFFFF.

## Operation
- Edge detect:
  - `src_d` is a register of `src_i`.
  - `edge = src_i & ~src_d & src_en_i`.
  - During reset, `src_d <= src_i`, so a source held high across reset never triggers.
- States are IDLE and HOLDOFF.
- IDLE, when `|edge` is true:
  - Accept if `!disable_i && !busy_o`.
  - On accept:
    - `trig_o` = 1.
    - `trig_buf_o` = `wr_ptr`.
    - `trig_type_o` = `edge`.
    - Set `buf_status[wr_ptr]`.
    - `wr_ptr` += 1, mod `NUM_BUF`.
    - `evt_count` += 1.
    - Load holdoff counter with `holdoff_i`.
    - Go to HOLDOFF if `holdoff_i != 0`, else stay in IDLE.
  - Otherwise reject: `lost_count` += 1, saturating.
- HOLDOFF:
  - Counter decrements each cycle; go to IDLE the cycle it reaches 0.
  - Any `|edge` here is rejected and counted.
  - `disable_i` does not stop the counter.
- Multiple simultaneous source edges produce one trigger; `trig_type_o` has multiple bits set.
- `clr_evt_i`:
  - If any buffer is occupied: clear `buf_status[rd_ptr]`; `rd_ptr` += 1, mod `NUM_BUF`.
  - If empty: ignored, no pointer change.
- Trigger and `clr_evt_i` in the same cycle: both apply; occupancy count is unchanged.
- Full check uses the registered state. An edge arriving while full is rejected even if `clr_evt_i` is high in the same cycle.
- `busy_o` is high when occupancy count equals `NUM_BUF`.
- `lost_count` counts cycles, not sources: +1 per rejecting cycle regardless of popcount.

## Timing
- Reset values:
  - `trig_o` = 0, `trig_buf_o` = 0, `trig_type_o` = 0.
  - `buf_status_o` = 0, `busy_o` = 0.
  - `evt_count_o` = 0, `lost_count_o` = 0.
  - Pointers = 0, state IDLE.
- Latency: `src_i` low at edge k−1 and high at edge k gives `trig_o` high for the cycle after edge k (1 clock). All outputs are registered.
- `holdoff_i` = H > 0:
  - A next edge is accepted no earlier than H+1 cycles after the `trig_o` cycle.
  - `holdoff_i` is sampled only at acceptance.
- `holdoff_i` = 0: back-to-back triggers on consecutive edges are allowed.
- `buf_status_o`, `busy_o` and the counters update in the same cycle as `trig_o`. `clr_evt_i` takes effect on the next edge.
- `rst_i` mid-holdoff or with buffers occupied returns everything to reset values on the next edge. No `trig_o` is emitted that cycle.

## Test plan
- Reset, then a single rising edge on src 0 (enabled, holdoff 0): one `trig_o` pulse one cycle later; `trig_buf_o`=0, `trig_type_o`=0001, `buf_status_o`=0001, `evt_count_o`=1.
- Src 1 and src 2 rise in the same cycle: exactly one `trig_o`; `trig_type_o`=0110. Src 3 disabled and rising: no trigger and no lost count.
- `holdoff_i`=5, three edges spaced 3 cycles apart: first accepted, second rejected (`lost_count_o`=1), third accepted.
- Four triggers with no `clr_evt_i` (`BUF_BITS`=2): `busy_o`=1, `buf_status_o`=1111. Fifth edge is rejected even with `clr_evt_i` in the same cycle. After the clear, the next edge gets `trig_buf_o`=0.
- `clr_evt_i` while empty: no change. Simultaneous trigger and clear with 2 buffers occupied: count stays 2, pointers advance correctly.
- `src_i` held high through `rst_i` deassertion: no trigger. `disable_i` high: 70000 rejected edges make `lost_count_o` saturate at 0xFFFF.
